elevator_controller: RTL

Floor-call scheduler and sequencer for the elevator. It latches single-cycle call pulses from the per-floor switch edge detectors into a pending-request register. It runs a directional (SCAN) policy to drive the motor up/down outputs and times floor travel and door dwell with internal counters. It sits between the switch-to-pulse front end and the motor/door/display outputs.

---
 rtl/elevator_controller.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/elevator_controller.sv
// -----------------------------------------------------------------------------
// elevator_controller
//
// Floor-call scheduler and motion sequencer. Single-cycle call pulses are
// latched into a pending-request vector. A SCAN policy keeps moving in the
// current direction while requests remain ahead, and reverses only when none
// are left. Internal counters time floor-to-floor travel and door dwell.
//
// Ports
//   clk         system clock, all state changes on the rising edge
//   reset       synchronous, active-high reset
//   call_pulse  one-cycle call pulses, bit i = call to floor i
//   floor       current floor index (registered)
//   motor_up    high while moving up
//   motor_down  high while moving down
//   door_open   high during door dwell
//   pending     registered pending-request vector
//   dir_up      current/last travel direction, 1 = up
// -----------------------------------------------------------------------------
module elevator_controller #(
  parameter int N_FLOORS      = 4,
  parameter int FLOOR_W       = 2,
  parameter int TRAVEL_CYCLES = 8,
  parameter int DOOR_CYCLES   = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_FLOORS-1:0] call_pulse,
  output logic [FLOOR_W-1:0]  floor,
  output logic                motor_up,
  output logic                motor_down,
  output logic                door_open,
  output logic [N_FLOORS-1:0] pending,
  output logic                dir_up
);

  localparam int TCNT_W = $clog2(TRAVEL_CYCLES);
  localparam int DCNT_W = $clog2(DOOR_CYCLES);
  localparam logic [TCNT_W-1:0] TRAVEL_LAST = TCNT_W'(TRAVEL_CYCLES - 1);
  localparam logic [DCNT_W-1:0] DOOR_LAST   = DCNT_W'(DOOR_CYCLES - 1);
  localparam logic [FLOOR_W-1:0] TOP_FLOOR  = FLOOR_W'(N_FLOORS - 1);

  typedef enum logic [1:0] {
    IDLE,
    MOVE_UP,
    MOVE_DOWN,
    DOOR
  } state_t;

  state_t              state, state_d;
  logic [FLOOR_W-1:0]  floor_d;
  logic [N_FLOORS-1:0] pending_d;
  logic                dir_up_d;
  logic [TCNT_W-1:0]   travel_cnt, travel_cnt_d;
  logic [DCNT_W-1:0]   dwell_cnt, dwell_cnt_d;

  // Requests as they stand on this edge, including the pulses being sampled.
  logic [N_FLOORS-1:0] pending_seen;
  logic [FLOOR_W-1:0]  floor_above, floor_below;

  function automatic logic [N_FLOORS-1:0] floor_bit(input logic [FLOOR_W-1:0] f);
    logic [N_FLOORS-1:0] b;
    b    = '0;
    b[f] = 1'b1;
    return b;
  endfunction

  function automatic logic any_above(input logic [N_FLOORS-1:0] vec,
                                     input logic [FLOOR_W-1:0]  f);
    logic r;
    r = 1'b0;
    for (int i = 0; i < N_FLOORS; i++)
      if (FLOOR_W'(i) > f) r = r | vec[i];
    return r;
  endfunction

  function automatic logic any_below(input logic [N_FLOORS-1:0] vec,
                                     input logic [FLOOR_W-1:0]  f);
    logic r;
    r = 1'b0;
    for (int i = 0; i < N_FLOORS; i++)
      if (FLOOR_W'(i) < f) r = r | vec[i];
    return r;
  endfunction

  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    state_d      = state;
    floor_d      = floor;
    dir_up_d     = dir_up;
    travel_cnt_d = travel_cnt;
    dwell_cnt_d  = dwell_cnt;
    pending_seen = pending | call_pulse;
    pending_d    = pending_seen;
    floor_above  = floor + FLOOR_W'(1);
    floor_below  = floor - FLOOR_W'(1);

    case (state)
      // IDLE decides from the registered request vector only, so a call
      // latched on this edge is acted on at the next one.
      IDLE: begin
        if (pending[floor]) begin
          state_d     = DOOR;
          dwell_cnt_d = '0;
          pending_d   = pending_seen & ~floor_bit(floor);
        end else if (dir_up && any_above(pending, floor)) begin
          state_d      = MOVE_UP;
          travel_cnt_d = '0;
        end else if (!dir_up && any_below(pending, floor)) begin
          state_d      = MOVE_DOWN;
          travel_cnt_d = '0;
        end else if (any_above(pending, floor)) begin
          state_d      = MOVE_UP;
          travel_cnt_d = '0;
          dir_up_d     = 1'b1;
        end else if (any_below(pending, floor)) begin
          state_d      = MOVE_DOWN;
          travel_cnt_d = '0;
          dir_up_d     = 1'b0;
        end
      end

      // On arrival the new floor is tested against requests including this
      // edge's pulses, so a late call for the arriving floor still stops us.
      MOVE_UP: begin
        if (travel_cnt == TRAVEL_LAST) begin
          floor_d      = floor_above;
          travel_cnt_d = '0;
          if (pending_seen[floor_above]) begin
            state_d     = DOOR;
            dwell_cnt_d = '0;
            pending_d   = pending_seen & ~floor_bit(floor_above);
          end else if (!any_above(pending_seen, floor_above)) begin
            state_d = IDLE;
          end
        end else begin
          travel_cnt_d = travel_cnt + TCNT_W'(1);
        end
      end

      MOVE_DOWN: begin
        if (travel_cnt == TRAVEL_LAST) begin
          floor_d      = floor_below;
          travel_cnt_d = '0;
          if (pending_seen[floor_below]) begin
            state_d     = DOOR;
            dwell_cnt_d = '0;
            pending_d   = pending_seen & ~floor_bit(floor_below);
          end else if (!any_below(pending_seen, floor_below)) begin
            state_d = IDLE;
          end
        end else begin
          travel_cnt_d = travel_cnt + TCNT_W'(1);
        end
      end

      // A call to this floor is absorbed and re-opens the door, which takes
      // priority over the dwell expiring on the same edge.
      DOOR: begin
        pending_d = pending_seen & ~floor_bit(floor);
        if (call_pulse[floor]) begin
          dwell_cnt_d = '0;
        end else if (dwell_cnt == DOOR_LAST) begin
          state_d = IDLE;
        end else begin
          dwell_cnt_d = dwell_cnt + DCNT_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      state      <= IDLE;
      floor      <= '0;
      pending    <= '0;
      dir_up     <= 1'b1;
      travel_cnt <= '0;
      dwell_cnt  <= '0;
    end else begin
      state      <= state_d;
      floor      <= floor_d;
      pending    <= pending_d;
      dir_up     <= dir_up_d;
      travel_cnt <= travel_cnt_d;
      dwell_cnt  <= dwell_cnt_d;
    end
  end

  assign motor_up   = (state == MOVE_UP);
  assign motor_down = (state == MOVE_DOWN);
  assign door_open  = (state == DOOR);

  a_floor_in_range: assert property (@(posedge clk) disable iff (reset)
    int'(floor) < N_FLOORS);
  a_no_up_at_top: assert property (@(posedge clk) disable iff (reset)
    motor_up |-> floor != TOP_FLOOR);
  a_no_down_at_ground: assert property (@(posedge clk) disable iff (reset)
    motor_down |-> floor != '0);
  a_outputs_exclusive: assert property (@(posedge clk) disable iff (reset)
    $onehot0({motor_up, motor_down, door_open}));

endmodule
